alu_add_stage: RTL and testbench

Arithmetic stage directly downstream of the quad XOR conditional-inverter in the 8-bit CPU ALU path.
- Captures operands A and B.
- Inverts B through XOR with the SUB line, then adds with carry-in = SUB, giving A+B or A−B.
- Registers the result and the carry/zero flags.
- Drives the result onto the CPU bus on request.
- Replaces the purely combinational adder with a 2-cycle registered stage that has a start/done handshake.

---
 rtl/alu_add_stage_pkg.sv | 18 +
 rtl/alu_add_stage_nibble_adder.sv | 22 ++
 rtl/alu_add_stage.sv | 118 +++++++++++
 tb/tb_alu_add_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/alu_add_stage_pkg.sv
// Shared definitions for the registered ALU add/subtract stage.
//   ALU_WIDTH : default datapath width (multiple of 4, one adder nibble per 4 bits)
//   ST_*      : FSM state encodings
package alu_add_stage_pkg;

   localparam int ALU_WIDTH = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CALC = ST_CALC,
      DONE = ST_DONE
   } state_e;

endpackage

// File: rtl/alu_add_stage_nibble_adder.sv
// 4-bit building blocks for the ALU add stage.
//   quad_xor     : four XOR gates, b ^ {4{inv}} (conditional inverter)
//     ports: b_i[3:0], inv_i -> y_o[3:0]
//   nibble_adder : 4-bit full adder with carry in/out (74xx283-equivalent)
//     ports: a_i[3:0], b_i[3:0], cin_i -> sum_o[3:0], cout_o
module quad_xor (
   input  logic [3:0] b_i,
   input  logic       inv_i,
   output logic [3:0] y_o
);
   assign y_o = b_i ^ {4{inv_i}};
endmodule

module nibble_adder (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);
   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'd0, cin_i};
endmodule

// File: rtl/alu_add_stage.sv
// Registered 2-cycle add/subtract stage with start/done handshake.
//   clk, rst_n            : clock (rising edge), async active-low reset
//   start                 : capture a_in/b_in/sub/flags_en (in IDLE or DONE)
//   a_in, b_in            : operands
//   sub                   : 1 = A + ~B + 1, 0 = A + B
//   flags_en              : update carry/zero flags when this op completes
//   out_en                : bus output enable
//   busy                  : high during CALC
//   done                  : one-cycle pulse when result_q/flags are valid
//   result_q              : registered result
//   bus_out, bus_drive    : result_q gated by out_en, and out_en itself
//   carry_flag, zero_flag : registered flags (carry=1 on subtract means no borrow)
module alu_add_stage
   import alu_add_stage_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             sub,
   input  logic             flags_en,
   input  logic             out_en,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_q,
   output logic [WIDTH-1:0] bus_out,
   output logic             bus_drive,
   output logic             carry_flag,
   output logic             zero_flag
);

   localparam int NIB = WIDTH / 4;

   if (WIDTH % 4 != 0 || WIDTH == 0) begin : g_width_chk
      $error("alu_add_stage: WIDTH must be a non-zero multiple of 4");
   end

   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             sub_q, fen_q;

   logic [WIDTH-1:0] b_x;
   logic [WIDTH-1:0] sum_d;
   logic [NIB:0]     carry;

   // Carry-in of the bottom nibble is the SUB line: two's-complement subtract.
   assign carry[0] = sub_q;

   for (genvar n = 0; n < NIB; n++) begin : g_nib
      quad_xor u_xor (
         .b_i   (b_q[4*n +: 4]),
         .inv_i (sub_q),
         .y_o   (b_x[4*n +: 4])
      );
      nibble_adder u_add (
         .a_i    (a_q[4*n +: 4]),
         .b_i    (b_x[4*n +: 4]),
         .cin_i  (carry[n]),
         .sum_o  (sum_d[4*n +: 4]),
         .cout_o (carry[n+1])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         sub_q      <= 1'b0;
         fen_q      <= 1'b0;
         result_q   <= '0;
         carry_flag <= 1'b0;
         zero_flag  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               // DONE accepts a new start too, giving one op every 2 cycles.
               done <= 1'b0;
               if (start) begin
                  a_q     <= a_in;
                  b_q     <= b_in;
                  sub_q   <= sub;
                  fen_q   <= flags_en;
                  busy    <= 1'b1;
                  state_q <= CALC;
               end else begin
                  busy    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            CALC: begin
               result_q <= sum_d;
               if (fen_q) begin
                  carry_flag <= carry[NIB];
                  zero_flag  <= (sum_d == '0);
               end
               busy    <= 1'b0;
               done    <= 1'b1;
               state_q <= DONE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus_out   = out_en ? result_q : '0;
   assign bus_drive = out_en;

endmodule

// File: tb/tb_alu_add_stage.sv
module tb_alu_add_stage;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic         flags_en = 1'b0;
   logic         out_en = 1'b0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;

   logic         busy, done, bus_drive, carry_flag, zero_flag;
   logic [W-1:0] result_q, bus_out;

   alu_add_stage #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a_in       (a_in),
      .b_in       (b_in),
      .sub        (sub),
      .flags_en   (flags_en),
      .out_en     (out_en),
      .busy       (busy),
      .done       (done),
      .result_q   (result_q),
      .bus_out    (bus_out),
      .bus_drive  (bus_drive),
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] r;
      logic         c;
      logic         z;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic push(input logic [W-1:0] r, input logic c, input logic z);
      exp_t e;
      e.r = r; e.c = c; e.z = z;
      q.push_back(e);
   endtask

   // Monitor: every done pulse must match the oldest expected response.
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = q.pop_front();
            chk("result", result_q, e.r);
            chk("carry",  carry_flag, e.c);
            chk("zero",   zero_flag, e.z);
         end
      end
   end

   // One isolated operation: start for a single edge, then wait out CALC and DONE.
   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                     input logic f, input logic [W-1:0] er, input logic ec, input logic ez);
      @(negedge clk);
      a_in = a; b_in = b; sub = s; flags_en = f; start = 1'b1;
      push(er, ec, ez);
      @(negedge clk);
      start = 1'b0;
      chk("busy_in_calc", busy, 1);
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_result", result_q, 0);
      chk("rst_flags", {carry_flag, zero_flag}, 0);
      chk("rst_busy_done", {busy, done}, 0);
      chk("rst_bus", bus_out, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      op(8'h05, 8'h03, 1'b0, 1'b1, 8'h08, 1'b0, 1'b0);
      op(8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
      op(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
      op(8'h03, 8'h05, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
      op(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
      op(8'h02, 8'h02, 1'b0, 1'b0, 8'h04, 1'b1, 1'b1);  // flags hold
      op(8'h0F, 8'h01, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0);  // nibble carry
      op(8'hA5, 8'h5A, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
      op(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0);

      // start held high: captures at IDLE, then every DONE; CALC values ignored
      @(negedge clk);
      start = 1'b1; sub = 1'b0; flags_en = 1'b1;
      a_in = 8'h01; b_in = 8'h01; push(8'h02, 1'b0, 1'b0);
      @(negedge clk);
      a_in = 8'h10; b_in = 8'h10;                       // ignored
      @(negedge clk);
      a_in = 8'h20; b_in = 8'h03; push(8'h23, 1'b0, 1'b0);
      @(negedge clk);
      a_in = 8'h07; b_in = 8'h07; sub = 1'b1;           // ignored
      @(negedge clk);
      a_in = 8'h30; b_in = 8'h10; sub = 1'b1; push(8'h20, 1'b1, 1'b0);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", busy, 1);
      repeat (2) @(negedge clk);
      chk("b2b_idle", {busy, done}, 0);

      // bus gating
      out_en = 1'b1; #1;
      chk("bus_on", bus_out, 8'h20);
      chk("drive_on", bus_drive, 1);
      out_en = 1'b0; #1;
      chk("bus_off", bus_out, 0);
      chk("drive_off", bus_drive, 0);

      // start with out_en high: old result until the new one registers
      @(negedge clk);
      out_en = 1'b1; a_in = 8'h40; b_in = 8'h02; sub = 1'b0; flags_en = 1'b1; start = 1'b1;
      push(8'h42, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      chk("bus_old_in_calc", bus_out, 8'h20);
      @(negedge clk);
      chk("bus_new", bus_out, 8'h42);
      out_en = 1'b0;

      op(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0);

      // reset mid-CALC: abandoned, no done pulse
      @(negedge clk);
      a_in = 8'h10; b_in = 8'h20; sub = 1'b0; flags_en = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_before_rst", busy, 1);
      #2 rst_n = 1'b0; #1;
      chk("midrst_result", result_q, 0);
      chk("midrst_flags", {carry_flag, zero_flag}, 0);
      chk("midrst_busy_done", {busy, done}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      op(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);

      // drain with a bound
      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("queue_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
